spal_ctrl: RTL and testbench

SPAL_CTRL -- requirements
Module: spal_ctrl

---
 rtl/spal_pkg.sv | 13 +
 rtl/spal_if.sv | 28 ++
 rtl/spal_ramp_tmr.sv | 24 ++
 rtl/spal_ctrl.sv | 98 +++++++++
 tb/tb_spal_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/spal_pkg.sv
// Shared state encoding for the spin-speed controller.
package spal_pkg;

    // Codes 5-7 are unused; the controller recovers from them to OFF.
    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_IDLE      = 3'd1,
        ST_RAMP_UP   = 3'd2,
        ST_RUN       = 3'd3,
        ST_RAMP_DOWN = 3'd4
    } spal_state_e;

endpackage

// File: rtl/spal_if.sv
// Control inputs and status outputs of the spin-speed controller.
interface spal_if #(
    parameter int NUM_SPEEDS = 4
);
    localparam int SPD_W = $clog2(NUM_SPEEDS + 1);

    logic             on_off;
    logic             door_closed;
    logic [SPD_W-1:0] speed_req;
    logic [2:0]       state;
    logic [SPD_W-1:0] speed_level;
    logic             led_on;
    logic             led_speed;
    logic             door_lock;
    logic             busy;

    // Panel / host side: drives requests, observes status.
    modport master (
        output on_off, door_closed, speed_req,
        input  state, speed_level, led_on, led_speed, door_lock, busy
    );

    // Controller side.
    modport slave (
        input  on_off, door_closed, speed_req,
        output state, speed_level, led_on, led_speed, door_lock, busy
    );
endinterface

// File: rtl/spal_ramp_tmr.sv
// Ramp pacing timer: counts 0..RAMP_CYCLES-1 while enabled, ticks on the
// last count and wraps so each level step restarts the interval.
module spal_ramp_tmr #(
    parameter int RAMP_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int TW = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;

    logic [TW-1:0] cnt;

    assign tick = en && (cnt == TW'(RAMP_CYCLES - 1));

    // Counter: clear on ramp entry, wrap on each step, hold when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              cnt <= '0;
        else if (clr || tick)  cnt <= '0;
        else if (en)           cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/spal_ctrl.sv
// Washing-machine spin-speed controller: power/door gating, clamped target,
// one-level-per-interval ramping and status decode from registered state.
module spal_ctrl
    import spal_pkg::*;
#(
    parameter int NUM_SPEEDS  = 4,
    parameter int RAMP_CYCLES = 8
) (
    input logic   clk,
    input logic   rst,
    spal_if.slave bus
);
    localparam int SPD_W = $clog2(NUM_SPEEDS + 1);
    localparam logic [SPD_W-1:0] MAX_LVL = SPD_W'(NUM_SPEEDS);

    spal_state_e      st, st_n;
    logic [SPD_W-1:0] lvl, lvl_n;
    logic [SPD_W-1:0] req_c, tgt;
    logic             ramping, tmr_clr, tick;

    // Target level: clamp the request, force 0 when off or door open.
    always_comb begin
        req_c = (bus.speed_req > MAX_LVL) ? MAX_LVL : bus.speed_req;
        tgt   = (bus.on_off && bus.door_closed) ? req_c : '0;
    end

    assign ramping = (st == ST_RAMP_UP) || (st == ST_RAMP_DOWN);
    // Any edge that does not keep us in the same ramp state restarts the
    // interval, which covers ramp entry and direction reversal.
    assign tmr_clr = !(ramping && (st_n == st));

    spal_ramp_tmr #(.RAMP_CYCLES(RAMP_CYCLES)) u_tmr (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmr_clr),
        .en   (ramping),
        .tick (tick)
    );

    // State and level registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st  <= ST_OFF;
            lvl <= '0;
        end else begin
            st  <= st_n;
            lvl <= lvl_n;
        end
    end

    // Next state / next level.
    always_comb begin
        st_n  = st;
        lvl_n = lvl;
        case (st)
            ST_OFF: begin
                lvl_n = '0;
                if (bus.on_off) st_n = ST_IDLE;
            end
            ST_IDLE: begin
                if (!bus.on_off)    st_n = ST_OFF;
                else if (tgt != '0) st_n = ST_RAMP_UP;
            end
            ST_RUN: begin
                if (tgt > lvl)      st_n = ST_RAMP_UP;
                else if (tgt < lvl) st_n = ST_RAMP_DOWN;
            end
            ST_RAMP_UP, ST_RAMP_DOWN: begin
                // Exit is checked before any step.
                if (lvl == tgt) begin
                    if (lvl != '0)       st_n = ST_RUN;
                    else if (bus.on_off) st_n = ST_IDLE;
                    else                 st_n = ST_OFF;
                end else if (tgt > lvl) begin
                    if (st == ST_RAMP_DOWN) st_n = ST_RAMP_UP;
                    else if (tick)          lvl_n = lvl + SPD_W'(1);
                end else begin
                    if (st == ST_RAMP_UP) st_n = ST_RAMP_DOWN;
                    else if (tick)        lvl_n = lvl - SPD_W'(1);
                end
            end
            default: begin
                st_n  = ST_OFF;
                lvl_n = '0;
            end
        endcase
    end

    // Status decode, registered state/level only.
    always_comb begin
        bus.state       = st;
        bus.speed_level = lvl;
        bus.led_on      = (st != ST_OFF);
        bus.led_speed   = (st == ST_RUN) && (lvl == MAX_LVL);
        bus.door_lock   = (lvl != '0);
        bus.busy        = ramping;
    end
endmodule

// File: tb/tb_spal_ctrl.sv
// Bench for spal_ctrl: directed scenarios plus random input churn, all
// compared cycle by cycle against a behavioural model.
module tb_spal_ctrl;
    localparam int N = 4;
    localparam int R = 4;
    localparam int S_OFF = 0, S_IDLE = 1, S_UP = 2, S_RUN = 3, S_DOWN = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    // model: state, level, cycles elapsed in the current ramp interval
    int m_st, m_lv, m_el;

    spal_if #(.NUM_SPEEDS(N)) bus ();

    spal_ctrl #(.NUM_SPEEDS(N), .RAMP_CYCLES(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = S_OFF; m_lv = 0; m_el = 0;
    endtask

    // One clock edge of the spec's behaviour, from the current inputs.
    task automatic model_edge();
        int tgt, dir;
        tgt = (bus.on_off && bus.door_closed) ? ((int'(bus.speed_req) > N) ? N : int'(bus.speed_req)) : 0;
        case (m_st)
            S_OFF:  if (bus.on_off) m_st = S_IDLE;
            S_IDLE: if (!bus.on_off) m_st = S_OFF;
                    else if (tgt > 0) begin m_st = S_UP; m_el = 0; end
            S_RUN:  if (tgt != m_lv) begin m_st = (tgt > m_lv) ? S_UP : S_DOWN; m_el = 0; end
            default: begin
                if (tgt == m_lv) begin
                    m_st = (m_lv > 0) ? S_RUN : (bus.on_off ? S_IDLE : S_OFF);
                end else begin
                    dir = (tgt > m_lv) ? S_UP : S_DOWN;
                    if (dir != m_st) begin
                        m_st = dir; m_el = 0;
                    end else begin
                        m_el++;
                        if (m_el == R) begin
                            m_lv += (dir == S_UP) ? 1 : -1;
                            m_el = 0;
                        end
                    end
                end
            end
        endcase
    endtask

    task automatic compare_all();
        chk("state", int'(bus.state), m_st);
        chk("speed_level", int'(bus.speed_level), m_lv);
        chk("led_on", int'(bus.led_on), int'(m_st != S_OFF));
        chk("led_speed", int'(bus.led_speed), int'(m_st == S_RUN && m_lv == N));
        chk("door_lock", int'(bus.door_lock), int'(m_lv != 0));
        chk("busy", int'(bus.busy), int'(m_st == S_UP || m_st == S_DOWN));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Pulse reset between edges and check outputs clear before the next edge.
    task automatic pulse_reset();
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("rst_state", int'(bus.state), S_OFF);
        chk("rst_level", int'(bus.speed_level), 0);
        chk("rst_leds", int'({bus.led_on, bus.led_speed, bus.door_lock, bus.busy}), 0);
        #1 rst = 1'b1;
    endtask

    initial begin
        bus.on_off = 1'b0; bus.door_closed = 1'b1; bus.speed_req = '0;
        model_reset();
        #12;
        compare_all();
        rst = 1'b1;

        // power on, no speed
        bus.on_off = 1'b1;
        step();
        chk("on_idle", int'(bus.state), S_IDLE);

        // ramp to full speed
        bus.speed_req = 3'd4;
        step();
        chk("up_entry", int'(bus.state), S_UP);
        for (int k = 1; k <= 4; k++) begin
            steps(R);
            chk("up_level", int'(bus.speed_level), k);
        end
        step();
        chk("run_full", int'(bus.state), S_RUN);
        chk("led_speed_full", int'(bus.led_speed), 1);

        // out-of-range request clamps, then ramp down to 1
        bus.speed_req = 3'd7;
        steps(3);
        chk("clamp_lvl", int'(bus.speed_level), 4);
        bus.speed_req = 3'd1;
        step();
        chk("down_entry", int'(bus.state), S_DOWN);
        for (int k = 3; k >= 1; k--) begin
            steps(R);
            chk("down_level", int'(bus.speed_level), k);
        end
        step();
        chk("run_one", int'(bus.state), S_RUN);

        // run at 2, then power off ramps to 0 and OFF
        bus.speed_req = 3'd2;
        steps(1 + R + 1);
        chk("run_two", int'(bus.state), S_RUN);
        bus.on_off = 1'b0;
        step();
        chk("off_down", int'(bus.state), S_DOWN);
        steps(2 * R);
        chk("off_lock", int'(bus.door_lock), 0);
        step();
        chk("off_final", int'(bus.state), S_OFF);

        // door opens mid-ramp: reversal without a level change
        bus.on_off = 1'b1;
        step();
        bus.speed_req = 3'd4;
        steps(1 + 2 * R + 2);
        bus.door_closed = 1'b0;
        step();
        chk("rev_state", int'(bus.state), S_DOWN);
        chk("rev_level", int'(bus.speed_level), 2);
        steps(R);
        chk("rev_l1", int'(bus.speed_level), 1);
        steps(R + 1);
        chk("rev_idle", int'(bus.state), S_IDLE);

        // reset while running at 3
        bus.door_closed = 1'b1;
        bus.speed_req = 3'd3;
        steps(1 + 3 * R + 1);
        chk("pre_rst_run", int'(bus.state), S_RUN);
        pulse_reset();
        step();

        // random churn
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) bus.speed_req = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0) bus.on_off = ~bus.on_off;
            if ($urandom_range(0, 29) == 0) bus.door_closed = ~bus.door_closed;
            if ($urandom_range(0, 399) == 0) pulse_reset();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
